// File: rtl/seq_frame_tx_if.sv
// ----------------------------------------------------------------------------
// seq_frame_tx_if
// Load-side handshake bundle for the serial frame transmitter.
//
// Signals:
//   LOAD   payload valid, driven by the producer
//   DIN    payload word, DATA_W bits, driven by the producer
//   READY  transmitter idle and able to accept LOAD, driven by the transmitter
//
// Modports:
//   master  producer side (drives LOAD/DIN, observes READY)
//   slave   transmitter side (observes LOAD/DIN, drives READY)
// ----------------------------------------------------------------------------
interface seq_frame_tx_if #(
  parameter int DATA_W = 8
);

  logic              LOAD;
  logic [DATA_W-1:0] DIN;
  logic              READY;

  modport master (
    output LOAD,
    output DIN,
    input  READY
  );

  modport slave (
    input  LOAD,
    input  DIN,
    output READY
  );

endinterface

// File: rtl/seq_frame_tx.sv
// ----------------------------------------------------------------------------
// seq_frame_tx
// Serial frame transmitter feeding the sync-pattern detector. A payload word
// accepted over the load handshake is sent on one registered bit line as:
//   sync pattern (MSB first) | payload (MSB first) | [parity] | idle gap
// one bit per CLK. Completed frames are counted in a saturating 3-bit counter.
//
// Ports:
//   CLK         clock, all state changes on the rising edge
//   RST         synchronous, active-high reset (highest priority)
//   CNT_CLR     synchronous clear of FRAME_CNT (wins over an increment)
//   load_if     slave side of seq_frame_tx_if (LOAD, DIN in / READY out)
//   X_OUT       registered serial bit stream
//   BUSY        frame in progress (inverse of READY outside reset)
//   FRAME_DONE  one-cycle pulse during the final gap cycle of a frame
//   FRAME_CNT   completed frames, saturating at 7
//
// Build option:
//   SEQ_FRAME_TX_PARITY_EN  when defined, a PAR state after DATA sends the
//                           even parity (XOR) of the captured payload.
//                           When undefined no parity logic exists.
// ----------------------------------------------------------------------------
module seq_frame_tx #(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1001,
  parameter int                GAP_LEN  = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                CNT_CLR,
  seq_frame_tx_if.slave       load_if,
  output logic                X_OUT,
  output logic                BUSY,
  output logic                FRAME_DONE,
  output logic [2:0]          FRAME_CNT
);

  // The per-state bit counter must reach the longest of the three segments.
  localparam int MAX_SEG = (DATA_W > SYNC_W)
                           ? ((DATA_W > GAP_LEN) ? DATA_W : GAP_LEN)
                           : ((SYNC_W > GAP_LEN) ? SYNC_W : GAP_LEN);
  localparam int CNT_W   = $clog2(MAX_SEG + 1);

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);

  // The state names the segment whose bit is on X_OUT in the current cycle.
  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
`ifdef SEQ_FRAME_TX_PARITY_EN
    S_PAR,
`endif
    S_GAP
  } state_t;

  state_t            state_q,  state_nxt;
  logic [CNT_W-1:0]  cnt_q,    cnt_nxt;
  logic [DATA_W-1:0] data_q,   data_nxt;
  logic [SYNC_W-1:0] sync_q,   sync_nxt;
  logic              x_q,      x_nxt;
  logic              ready_q,  ready_nxt;
  logic              busy_q,   busy_nxt;
  logic              done_q,   done_nxt;
  logic [2:0]        fcnt_q,   fcnt_nxt;
  logic              frame_end;
  logic [CNT_W-1:0]  cnt_inc;

`ifdef SEQ_FRAME_TX_PARITY_EN
  logic              par_q,    par_nxt;
`endif

  assign cnt_inc = cnt_q + 1'b1;

  // Next-state and next-output logic. Outputs are computed one cycle ahead
  // and registered, so the bit that belongs to a state is already on X_OUT
  // during the first cycle of that state.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    data_nxt  = data_q;
    sync_nxt  = sync_q;
    x_nxt     = 1'b0;
    ready_nxt = ready_q;
    done_nxt  = 1'b0;
    frame_end = 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
    par_nxt   = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        // The sync MSB goes out at the capture edge itself; the remaining
        // sync bits are preloaded already shifted by one position.
        if (load_if.LOAD) begin
          state_nxt = S_SYNC;
          cnt_nxt   = '0;
          data_nxt  = load_if.DIN;
          sync_nxt  = SYNC_PAT << 1;
          x_nxt     = SYNC_PAT[SYNC_W-1];
          ready_nxt = 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
          par_nxt   = ^load_if.DIN;
`endif
        end
      end

      S_SYNC: begin
        if (cnt_q == SYNC_LAST) begin
          state_nxt = S_DATA;
          cnt_nxt   = '0;
          x_nxt     = data_q[DATA_W-1];
          data_nxt  = data_q << 1;
        end else begin
          cnt_nxt   = cnt_inc;
          x_nxt     = sync_q[SYNC_W-1];
          sync_nxt  = sync_q << 1;
        end
      end

      S_DATA: begin
        if (cnt_q == DATA_LAST) begin
          cnt_nxt   = '0;
`ifdef SEQ_FRAME_TX_PARITY_EN
          state_nxt = S_PAR;
          x_nxt     = par_q;
`else
          state_nxt = S_GAP;
          x_nxt     = 1'b0;
          done_nxt  = (GAP_LEN == 1);
`endif
        end else begin
          cnt_nxt   = cnt_inc;
          x_nxt     = data_q[DATA_W-1];
          data_nxt  = data_q << 1;
        end
      end

`ifdef SEQ_FRAME_TX_PARITY_EN
      S_PAR: begin
        state_nxt = S_GAP;
        cnt_nxt   = '0;
        x_nxt     = 1'b0;
        done_nxt  = (GAP_LEN == 1);
      end
`endif

      S_GAP: begin
        // FRAME_DONE is raised when entering the final gap cycle, so it
        // lines up with that cycle rather than trailing it.
        if (cnt_q == GAP_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          ready_nxt = 1'b1;
          frame_end = 1'b1;
        end else begin
          cnt_nxt   = cnt_inc;
          done_nxt  = (cnt_inc == GAP_LAST);
        end
      end

      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
        ready_nxt = 1'b1;
      end
    endcase
  end

  // BUSY is simply the registered complement of READY.
  assign busy_nxt = ~ready_nxt;

  // Frame counter: clear beats a coincident completion, and the count
  // sticks at 7 instead of wrapping.
  always_comb begin
    fcnt_nxt = fcnt_q;
    if (CNT_CLR) begin
      fcnt_nxt = 3'd0;
    end else if (frame_end && (fcnt_q != 3'd7)) begin
      fcnt_nxt = fcnt_q + 3'd1;
    end
  end

  // State and output registers. Reset abandons any frame in flight and
  // clears the shift registers along with the counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      sync_q  <= '0;
      x_q     <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fcnt_q  <= 3'd0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      data_q  <= data_nxt;
      sync_q  <= sync_nxt;
      x_q     <= x_nxt;
      ready_q <= ready_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      fcnt_q  <= fcnt_nxt;
    end
  end

`ifdef SEQ_FRAME_TX_PARITY_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_nxt;
    end
  end
`endif

  assign load_if.READY = ready_q;
  assign X_OUT         = x_q;
  assign BUSY          = busy_q;
  assign FRAME_DONE    = done_q;
  assign FRAME_CNT     = fcnt_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// ----------------------------------------------------------------------------
// tb_seq_frame_tx
// Directed bench for seq_frame_tx with default parameters (8-bit payload,
// sync 1001, one gap bit). Expected frames are built from the payload by
// frameBits(); a small 1001 matcher stands in for the downstream detector.
// ----------------------------------------------------------------------------
module tb_seq_frame_tx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CNT_CLR;
  logic       X_OUT;
  logic       BUSY;
  logic       FRAME_DONE;
  logic [2:0] FRAME_CNT;

  int checks = 0;
  int errors = 0;

  // Downstream detector stand-in
  logic [3:0] hist      = 4'b0000;
  int         sinceLoad = 0;
  int         detCount  = 0;
  bit         detEnable = 1'b0;

`ifdef SEQ_FRAME_TX_PARITY_EN
  localparam int FLEN = 14;
`else
  localparam int FLEN = 13;
`endif

  seq_frame_tx_if #(.DATA_W(8)) loadBus ();

  seq_frame_tx #(
    .DATA_W   (8),
    .SYNC_W   (4),
    .SYNC_PAT (4'b1001),
    .GAP_LEN  (1)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .CNT_CLR    (CNT_CLR),
    .load_if    (loadBus),
    .X_OUT      (X_OUT),
    .BUSY       (BUSY),
    .FRAME_DONE (FRAME_DONE),
    .FRAME_CNT  (FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  // Expected bit sequence of one frame, MSB = first bit on the line.
  function automatic logic [15:0] frameBits(input logic [7:0] d);
`ifdef SEQ_FRAME_TX_PARITY_EN
    return {2'b00, 4'b1001, d, ^d, 1'b0};
`else
    return {3'b000, 4'b1001, d, 1'b0};
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one edge worth of inputs, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic rst, input logic load,
                               input logic [7:0] din, input logic clr);
    logic capture;
    RST          = rst;
    loadBus.LOAD = load;
    loadBus.DIN  = din;
    CNT_CLR      = clr;
    capture      = load && (loadBus.READY === 1'b1) && !rst;
    @(posedge CLK);
    #1;
    if (rst) begin
      hist = 4'b0000;
    end else begin
      hist = {hist[2:0], X_OUT};
    end
    sinceLoad = capture ? 1 : sinceLoad + 1;
    if (detEnable && hist == 4'b1001) begin
      detCount++;
      checkOutput("detector hit position", sinceLoad, 4);
    end
  endtask

  task automatic checkIdle(input string tag, input int cnt);
    checkOutput({tag, " X_OUT"}, X_OUT, 0);
    checkOutput({tag, " READY"}, loadBus.READY, 1);
    checkOutput({tag, " BUSY"}, BUSY, 0);
    checkOutput({tag, " FRAME_DONE"}, FRAME_DONE, 0);
    checkOutput({tag, " FRAME_CNT"}, FRAME_CNT, cnt);
  endtask

  // Send one frame from IDLE and check every bit time. LOAD is pulsed with
  // pulseDin during cycle pulseAt (0 = never).
  task automatic runFrame(input logic [7:0] d, input int pulseAt,
                          input logic [7:0] pulseDin);
    logic [15:0] exp;
    exp = frameBits(d);
    applyStimulus(1'b0, 1'b1, d, 1'b0);
    for (int i = 1; i <= FLEN; i++) begin
      checkOutput($sformatf("frame %0h bit %0d", d, i), X_OUT, exp[FLEN-i]);
      checkOutput($sformatf("frame %0h done %0d", d, i), FRAME_DONE, (i == FLEN));
      checkOutput($sformatf("frame %0h ready %0d", d, i), loadBus.READY, 0);
      checkOutput($sformatf("frame %0h busy %0d", d, i), BUSY, 1);
      if (i == pulseAt) begin
        applyStimulus(1'b0, 1'b1, pulseDin, 1'b0);
      end else begin
        applyStimulus(1'b0, 1'b0, ~d, 1'b0);
      end
    end
    checkOutput("frame end READY", loadBus.READY, 1);
    checkOutput("frame end BUSY", BUSY, 0);
    checkOutput("frame end X_OUT", X_OUT, 0);
  endtask

  initial begin
    RST          = 1'b1;
    CNT_CLR      = 1'b0;
    loadBus.LOAD = 1'b0;
    loadBus.DIN  = 8'h00;

    // Reset then idle
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkIdle("reset", 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      checkIdle("idle", 0);
    end

    // Single frame A5
    runFrame(8'hA5, 0, 8'h00);
    checkOutput("A5 FRAME_CNT", FRAME_CNT, 1);

    // LOAD during busy is ignored
    runFrame(8'h3C, 5, 8'hFF);
    checkOutput("3C FRAME_CNT", FRAME_CNT, 2);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkIdle("after 3C", 2);

    // Reset at cycle 6 of an A5 frame
    applyStimulus(1'b0, 1'b1, 8'hA5, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkIdle("mid-frame reset", 0);
    for (int i = 0; i < FLEN; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      checkIdle("post reset", 0);
    end

    // Nine back-to-back frames, clear on the ninth completion
    for (int f = 1; f <= 9; f++) begin
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
      checkOutput($sformatf("b2b %0d first bit", f), X_OUT, 1);
      for (int c = 1; c < FLEN; c++) begin
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
      end
      checkOutput($sformatf("b2b %0d done", f), FRAME_DONE, 1);
      applyStimulus(1'b0, (f < 9), 8'h00, (f == 9));
      checkOutput($sformatf("b2b %0d ready", f), loadBus.READY, 1);
      checkOutput($sformatf("b2b %0d FRAME_CNT", f), FRAME_CNT,
                  (f == 9) ? 0 : ((f > 7) ? 7 : f));
    end

    // Detector loopback: three frames of 00
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    detEnable = 1'b1;
    for (int f = 0; f < 3; f++) begin
      runFrame(8'h00, 0, 8'h00);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    detEnable = 1'b0;
    checkOutput("detector hit count", detCount, 3);
    checkOutput("loopback FRAME_CNT", FRAME_CNT, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
